md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Issue and hazard controller for the pipeline's multiply/divide unit (HI/LO unit). It decodes the multiply/divide-class instruction in EX, drives the unit's 3-bit operation code, and tracks the operation latency with its own counter. It raises a stall to freeze IF/ID while an ID-stage multiply/divide-class instruction would collide with an in-flight operation. It sits between the ID/EX pipeline registers and the HI/LO unit, alongside the main hazard unit.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_md_op  in  4  op class of ID instruction (md_pkg encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo)
- ex_md_op  in  4  op class of EX instruction, same encoding
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- flush  in  1  EX instruction killed this cycle (exception)
- xalu_op  out  3  unit op code: 000 none, 001 read, 010 mtlo, 011 mthi, 100 div, 101 divu, 110 mult, 111 multu
- busy  out  1  operation in flight (registered)
- stall  out  1  freeze PC/IF/ID, insert bubble into EX
- done  out  1  one-cycle pulse, HI/LO result committed

## Operation
- States: IDLE, MUL, DIV. The latency counter is 4 bits.
- Issue condition: state IDLE, ex_valid=1, flush=0, ex_md_op in 1..4.
  - xalu_op is driven combinationally with the matching code during the issue cycle.
  - On the next edge: mult/multu go to MUL with cnt=MULT_CYCLES; div/divu go to DIV with cnt=DIV_CYCLES.
- mthi/mtlo/mfhi/mflo in EX while IDLE with ex_valid=1 and flush=0: xalu_op=011/010/001/001. No state change.
- In MUL/DIV: cnt decrements each edge. On the edge where cnt==1: state goes to IDLE, cnt to 0, and done=1 for the following cycle.
- busy = (state != IDLE).
- Any op-class value in EX while busy: xalu_op=000 and the operation is not issued. Normal flow never reaches this because stall prevents it.
- flush=1 or ex_valid=0: xalu_op=000.
- flush has no effect on an operation already in flight; it runs to completion.
- stall = (id_md_op != 0) AND (busy OR issue condition true this cycle).
- stall never depends on ex_md_op classes 5..8.
- Unknown op-class values 9..15 are treated as none in both ID and EX.

## Timing
- Reset values: busy=0, done=0, state IDLE, cnt=0. Combinational outputs xalu_op=000 and stall=0 while reset is held.
- Issue in cycle T. busy=1 in cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
- busy=0 and done=1 in cycle T+N+1. HI/LO are valid from T+N+1.
- An mfhi/mflo held in ID is released (stall=0) in cycle T+N+1 and reaches EX in T+N+2.
- Back-to-back mult: the second mult, held in ID, issues in T+N+2. There are no dead cycles beyond the stall.
- Reset mid-operation: the next cycle is IDLE with busy=0, and no done pulse is generated.
- done and a new issue may coincide in the same cycle (T+N+1) only if the EX instruction entered before the stall. This is legal, and busy re-asserts in the next cycle.

## Configuration
- MD_DIV_EN defined: div/divu are supported as described, using DIV_CYCLES.
- MD_DIV_EN undefined:
  - the DIV state and the DIV_CYCLES logic are removed;
  - div/divu in EX yield xalu_op=000 and cause no state change;
  - id_md_op values 3 and 4 do not contribute to stall.

## Structure
- md_pkg holds:
  - op-class constants (MD_NONE .. MD_MFLO);
  - xalu_op code constants (XOP_NONE, XOP_READ, XOP_MTLO, XOP_MTHI, XOP_DIV, XOP_DIVU, XOP_MULT, XOP_MULTU);
  - state encoding constants.
- One sub-module, md_latency_counter: load value, load enable, decrement, last-cycle flag (cnt==1). It is instantiated once.

## Test plan
- mult in EX (ex_valid=1), MULT_CYCLES=5, issued at cycle 10 -> xalu_op=110 in cycle 10; busy in cycles 11..15; done in cycle 16.
- mult issued at cycle 10 with mflo in ID -> stall=1 in cycles 10..15, stall=0 in cycle 16.
- div with MD_DIV_EN, issued at cycle 20 -> xalu_op=100; busy in cycles 21..30; done in cycle 31. The same test without MD_DIV_EN -> xalu_op=000, busy stays 0, stall=0 for div in ID.
- mult in EX with flush=1 -> xalu_op=000, busy stays 0. A flush asserted in cycle 12 during an in-flight op -> done still pulses in cycle 16.
- reset asserted in cycle 13 during a mult issued at cycle 10 -> busy=0 from cycle 14, no done pulse; the next mult issues normally.
- mthi in EX while idle -> xalu_op=011, stall=0. ID mfhi behind it -> no stall.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide issue controller: op classes,
// HI/LO unit operation codes, FSM state encoding and op-class helpers.
package md_pkg;

    localparam int unsigned MD_OP_W  = 4;
    localparam int unsigned XOP_W    = 3;
    localparam int unsigned MD_CNT_W = 4;
    localparam int unsigned ST_W     = 2;

    // Op classes as decoded by ID/EX; values 9..15 are treated as none.
    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

    // Operation codes driven to the HI/LO unit.
    localparam logic [XOP_W-1:0] XOP_NONE  = 3'b000;
    localparam logic [XOP_W-1:0] XOP_READ  = 3'b001;
    localparam logic [XOP_W-1:0] XOP_MTLO  = 3'b010;
    localparam logic [XOP_W-1:0] XOP_MTHI  = 3'b011;
    localparam logic [XOP_W-1:0] XOP_DIV   = 3'b100;
    localparam logic [XOP_W-1:0] XOP_DIVU  = 3'b101;
    localparam logic [XOP_W-1:0] XOP_MULT  = 3'b110;
    localparam logic [XOP_W-1:0] XOP_MULTU = 3'b111;

    // FSM state encoding.
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_MUL  = 2'd1;
    localparam logic [ST_W-1:0] ST_DIV  = 2'd2;

    // mult/multu class.
    function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // div/divu class.
    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // HI/LO move class (mthi/mtlo/mfhi/mflo).
    function automatic logic md_is_hilo(input logic [MD_OP_W-1:0] op);
        return (op >= MD_MTHI) && (op <= MD_MFLO);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter tracking the remaining busy cycles of a multiply/divide.
// Loads on issue, decrements while in flight, flags the final busy cycle.
module md_latency_counter
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [MD_CNT_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_last_c
);

    logic [MD_CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - MD_CNT_W'(1);
        end
    end

    // Final busy cycle: the next edge returns the controller to idle.
    assign o_last_c = (r_cnt == MD_CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue and hazard controller for the HI/LO multiply/divide unit.
// Decodes the EX multiply/divide-class op, drives the unit op code, tracks
// latency and stalls IF/ID while an ID op would collide with a busy unit.
// Build option: MD_DIV_EN enables div/divu (DIV state and DIV_CYCLES);
// when undefined, div/divu are ignored in EX and never stall in ID.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] i_id_md_op,
    input  logic [MD_OP_W-1:0] i_ex_md_op,
    input  logic               i_ex_valid,
    input  logic               i_flush,
    output logic [XOP_W-1:0]   o_xalu_op_c,
    output logic               o_busy,
    output logic               o_stall_c,
    output logic               o_done
);

    // Latencies must fit the 4-bit counter and be non-zero.
    if ((MULT_CYCLES < 1) || (MULT_CYCLES > 15)) begin : g_bad_mult_cycles
        $error("md_issue_ctrl: MULT_CYCLES out of range 1..15");
    end
    if ((DIV_CYCLES < 1) || (DIV_CYCLES > 15)) begin : g_bad_div_cycles
        $error("md_issue_ctrl: DIV_CYCLES out of range 1..15");
    end

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
`ifdef MD_DIV_EN
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
`endif

    logic [ST_W-1:0]     r_state;
    logic                r_busy;
    logic                r_done;

    logic [ST_W-1:0]     w_state_nxt;
    logic [XOP_W-1:0]    w_xalu_op;
    logic                w_issue;
    logic                w_load;
    logic [MD_CNT_W-1:0] w_load_val;
    logic                w_done_nxt;
    logic                w_last;
    logic                w_ex_live;
    logic                w_id_md;

    // A real, surviving EX instruction outside reset.
    assign w_ex_live = i_ex_valid && !i_flush && !reset;

    // ID op classes that must wait for a busy or just-issuing unit.
`ifdef MD_DIV_EN
    assign w_id_md = md_is_mul(i_id_md_op) || md_is_div(i_id_md_op) || md_is_hilo(i_id_md_op);
`else
    assign w_id_md = md_is_mul(i_id_md_op) || md_is_hilo(i_id_md_op);
`endif

    md_latency_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (r_busy),
        .o_last_c   (w_last)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Next state, issue decode and unit op code.
    always_comb begin
        w_state_nxt = r_state;
        w_xalu_op   = XOP_NONE;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ex_live) begin
                    case (i_ex_md_op)
                        MD_MULT, MD_MULTU: begin
                            w_xalu_op   = (i_ex_md_op == MD_MULT) ? XOP_MULT : XOP_MULTU;
                            w_issue     = 1'b1;
                            w_load      = 1'b1;
                            w_load_val  = MULT_LOAD;
                            w_state_nxt = ST_MUL;
                        end
`ifdef MD_DIV_EN
                        MD_DIV, MD_DIVU: begin
                            w_xalu_op   = (i_ex_md_op == MD_DIV) ? XOP_DIV : XOP_DIVU;
                            w_issue     = 1'b1;
                            w_load      = 1'b1;
                            w_load_val  = DIV_LOAD;
                            w_state_nxt = ST_DIV;
                        end
`endif
                        MD_MTHI:          w_xalu_op = XOP_MTHI;
                        MD_MTLO:          w_xalu_op = XOP_MTLO;
                        MD_MFHI, MD_MFLO: w_xalu_op = XOP_READ;
                        default:          w_xalu_op = XOP_NONE;
                    endcase
                end
            end
            ST_MUL: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`ifdef MD_DIV_EN
            ST_DIV: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_xalu_op_c = w_xalu_op;
    assign o_stall_c   = !reset && w_id_md && (r_busy || w_issue);
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
// Each cycle drives inputs #1 after the edge and checks op code, stall,
// busy and done on the falling edge against hand-computed values.
// Div expectations follow MD_DIV_EN.
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned ND = 10;

    logic         clk;
    logic         reset;
    logic [3:0]   id_md_op;
    logic [3:0]   ex_md_op;
    logic         ex_valid;
    logic         flush;
    logic [2:0]   xalu_op;
    logic         busy;
    logic         stall;
    logic         done;

    int n_vec  = 0;
    int n_fail = 0;

    md_issue_ctrl #(.MULT_CYCLES(N), .DIV_CYCLES(ND)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_id_md_op  (id_md_op),
        .i_ex_md_op  (ex_md_op),
        .i_ex_valid  (ex_valid),
        .i_flush     (flush),
        .o_xalu_op_c (xalu_op),
        .o_busy      (busy),
        .o_stall_c   (stall),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check mid-cycle, advance past the next edge.
    task automatic cyc(input logic [3:0] ex, input logic v, input logic fl,
                       input logic [3:0] id, input logic rs,
                       input logic [2:0] e_x, input logic e_s,
                       input logic e_b, input logic e_d, input string tag);
        ex_md_op = ex; ex_valid = v; flush = fl; id_md_op = id; reset = rs;
        @(negedge clk);
        chk({tag, "/xop"},   32'(xalu_op), 32'(e_x));
        chk({tag, "/stall"}, 32'(stall),   32'(e_s));
        chk({tag, "/busy"},  32'(busy),    32'(e_b));
        chk({tag, "/done"},  32'(done),    32'(e_d));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] unk9;
        logic [3:0] unk12;
        unk9  = 4'd9;
        unk12 = 4'd12;
        reset = 1'b1; ex_md_op = MD_NONE; ex_valid = 1'b0; flush = 1'b0; id_md_op = MD_NONE;
        @(posedge clk);
        #1;

        // Reset: combinational outputs forced quiet even with a live mult.
        cyc(MD_MULT, 1, 0, MD_MFLO, 1, XOP_NONE, 0, 0, 0, "rst");
        cyc(MD_MULT, 1, 0, MD_MFLO, 1, XOP_NONE, 0, 0, 0, "rst2");

        // mult with mflo in ID: stall through busy, release on done.
        cyc(MD_MULT, 1, 0, MD_MFLO, 0, XOP_MULT, 1, 0, 0, "mul_iss");
        for (int i = 0; i < int'(N); i++)
            cyc(MD_NONE, 0, 0, MD_MFLO, 0, XOP_NONE, 1, 1, 0, "mul_busy");
        cyc(MD_NONE, 0, 0, MD_MFLO, 0, XOP_NONE, 0, 0, 1, "mul_done");
        cyc(MD_MFLO, 1, 0, MD_NONE, 0, XOP_READ, 0, 0, 0, "mflo_ex");

        // Flushed or bubble mult does not issue.
        cyc(MD_MULT, 1, 1, MD_MFLO, 0, XOP_NONE, 0, 0, 0, "flush_iss");
        cyc(MD_MULT, 0, 0, MD_MFLO, 0, XOP_NONE, 0, 0, 0, "bubble");
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 0, 0, "flush_idle");

        // In-flight: flush ignored, illegal EX op blocked, unknown ID op no stall.
        cyc(MD_MULT,  1, 0, MD_NONE, 0, XOP_MULT, 0, 0, 0, "iss2");
        cyc(MD_NONE,  0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "b1");
        cyc(MD_MULTU, 1, 1, MD_NONE, 0, XOP_NONE, 0, 1, 0, "b2_flush");
        cyc(MD_MULT,  1, 0, MD_MFHI, 0, XOP_NONE, 1, 1, 0, "b3_illegal");
        cyc(MD_NONE,  0, 0, unk9,    0, XOP_NONE, 0, 1, 0, "b4_unk_id");
        cyc(MD_NONE,  0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "b5");
        // done coincides with a new issue; mult in ID stalls on that issue.
        cyc(MD_MULTU, 1, 0, MD_MULT, 0, XOP_MULTU, 1, 0, 1, "coincide");
        for (int i = 0; i < int'(N); i++)
            cyc(MD_NONE, 0, 0, MD_MULT, 0, XOP_NONE, 1, 1, 0, "b2b_busy");
        cyc(MD_NONE, 0, 0, MD_MULT, 0, XOP_NONE, 0, 0, 1, "b2b_done");
        cyc(MD_MULT, 1, 0, MD_NONE, 0, XOP_MULT, 0, 0, 0, "b2b_iss");

        // Reset in the third busy cycle: no done pulse afterwards.
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "rm_b1");
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "rm_b2");
        cyc(MD_NONE, 0, 0, MD_MFLO, 1, XOP_NONE, 0, 1, 0, "rm_rst");
        for (int i = 0; i < int'(N) + 1; i++)
            cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 0, 0, "rm_after");
        cyc(MD_MULT, 1, 0, MD_NONE, 0, XOP_MULT, 0, 0, 0, "rm_iss");
        for (int i = 0; i < int'(N); i++)
            cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "rm_busy");
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 0, 1, "rm_done");

        // HI/LO moves while idle, unknown EX op.
        cyc(MD_MTHI, 1, 0, MD_MFHI, 0, XOP_MTHI, 0, 0, 0, "mthi");
        cyc(MD_MFHI, 1, 0, MD_NONE, 0, XOP_READ, 0, 0, 0, "mfhi");
        cyc(MD_MTLO, 1, 0, MD_NONE, 0, XOP_MTLO, 0, 0, 0, "mtlo");
        cyc(unk12,   1, 0, MD_MULT, 0, XOP_NONE, 0, 0, 0, "unk_ex");
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 0, 0, "unk_idle");

`ifdef MD_DIV_EN
        cyc(MD_DIV, 1, 0, MD_MFHI, 0, XOP_DIV, 1, 0, 0, "div_iss");
        for (int i = 0; i < int'(ND); i++)
            cyc(MD_NONE, 0, 0, MD_DIVU, 0, XOP_NONE, 1, 1, 0, "div_busy");
        cyc(MD_NONE, 0, 0, MD_DIVU, 0, XOP_NONE, 0, 0, 1, "div_done");
        cyc(MD_DIVU, 1, 0, MD_NONE, 0, XOP_DIVU, 0, 0, 0, "divu_iss");
        cyc(MD_NONE, 0, 0, MD_NONE, 0, XOP_NONE, 0, 1, 0, "divu_busy");
`else
        cyc(MD_DIV,  1, 0, MD_DIV,  0, XOP_NONE, 0, 0, 0, "div_off");
        cyc(MD_DIVU, 1, 0, MD_DIVU, 0, XOP_NONE, 0, 0, 0, "divu_off");
        cyc(MD_MULT, 1, 0, MD_DIV,  0, XOP_MULT, 0, 0, 0, "div_id_iss");
        cyc(MD_NONE, 0, 0, MD_DIVU, 0, XOP_NONE, 0, 1, 0, "divu_id_busy");
        cyc(MD_NONE, 0, 0, MD_MTLO, 0, XOP_NONE, 1, 1, 0, "mtlo_id_busy");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
